// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//   Handshaked, registered ALU that sits between register-file read and
//   writeback. Single-cycle ops finish in one cycle. Shifts move one bit per
//   cycle. The optional multiplier is a shift-add unit that adds one partial
//   product per cycle.
//
//   Optional feature macro: ALU_MUL_EN
//     defined   -> opcode 1000 is an iterative multiply and the MUL state exists
//     undefined -> no multiplier logic; opcode 1000 is illegal
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active high
//   in_valid   in   1      op/a/b valid
//   in_ready   out  1      block can accept an operation
//   op         in   4      opcode
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B / unsigned shift amount
//   out_valid  out  1      result and flags valid
//   out_ready  in   1      consumer takes the result
//   result     out  WIDTH  registered result
//   zero       out  1      result == 0 (a == b for CMP)
//   carry      out  1      carry / borrow / last bit shifted out
//   negative   out  1      sign bit of the result (of a-b for CMP)
//   overflow   out  1      signed overflow for ADD/SUB/CMP
//   err        out  1      illegal opcode for this build
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  // One extra bit so the iteration counter can hold WIDTH itself.
  localparam int CW  = SHW + 1;

  localparam logic [WIDTH-1:0] WIDTH_W   = WIDTH[WIDTH-1:0];
  localparam logic [CW-1:0]    WIDTH_CNT = WIDTH[CW-1:0];

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0010;
  localparam logic [3:0] OP_SHL = 4'b0011;
  localparam logic [3:0] OP_SHR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_CMP = 4'b0111;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
`endif

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL, ST_DONE} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_neg;
  logic             r_ovf;
  logic             r_err;
  logic [WIDTH-1:0] r_work;
  logic [CW-1:0]    r_cnt;
  logic             r_dirLeft;
  logic             r_bigShift;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_mulAcc;
`endif

  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_zero;
  logic             w_carry;
  logic             w_neg;
  logic             w_ovf;
  logic             w_err;
  state_t           w_nextState;
  logic [CW-1:0]    w_amt;
  logic [WIDTH-1:0] w_shiftNext;
  logic             w_shiftOut;

  // Handshake outputs are forced low while reset is held.
  assign in_ready  = !rst && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
  assign out_valid = !rst && (r_state == ST_DONE);
  assign w_accept  = in_valid && in_ready;

  assign result   = r_result;
  assign zero     = r_zero;
  assign carry    = r_carry;
  assign negative = r_neg;
  assign overflow = r_ovf;
  assign err      = r_err;

  // Add/subtract one bit wider than the operands so bit WIDTH is the
  // carry-out for ADD and the borrow (a < b unsigned) for SUB/CMP.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  // Shift amounts at or beyond WIDTH are capped at WIDTH iterations, which
  // always leaves a zero result.
  assign w_amt = (b >= WIDTH_W) ? WIDTH_CNT : b[CW-1:0];

  // One step of the iterative shifter and the bit it pushes out.
  assign w_shiftNext = r_dirLeft ? (r_work << 1) : (r_work >> 1);
  assign w_shiftOut  = r_dirLeft ? r_work[WIDTH-1] : r_work[0];

`ifdef ALU_MUL_EN
  // One shift-add partial product: add the multiplicand when the current
  // multiplier LSB is set; only the low WIDTH bits are kept.
  assign w_mulAcc = r_work + (r_mplier[0] ? r_mcand : '0);
`endif

  // Decode the incoming op: the single-cycle result and flags, plus which
  // state the FSM enters when the op is accepted.
  always_comb begin
    w_res       = '0;
    w_carry     = 1'b0;
    w_ovf       = 1'b0;
    w_err       = 1'b0;
    w_nextState = ST_DONE;
    case (op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT: w_res = ~a;
      OP_SHL, OP_SHR: begin
        w_res = a;
        if (b != '0) w_nextState = ST_SHIFT;
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_CMP: begin
        w_res   = {{(WIDTH-1){1'b0}}, w_diff[WIDTH]};
        w_carry = w_diff[WIDTH];
        w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
`ifdef ALU_MUL_EN
      OP_MUL: w_nextState = ST_MUL;
`endif
      default: w_err = 1'b1;
    endcase
    w_zero = (w_res == '0);
    w_neg  = w_res[WIDTH-1];
    // CMP reports the flags of a-b rather than of its 0/1 result.
    if (op == OP_CMP) begin
      w_zero = (w_diff[WIDTH-1:0] == '0);
      w_neg  = w_diff[WIDTH-1];
    end
  end

  // Main FSM. An accept in IDLE, or in DONE when the consumer is taking the
  // current result, loads the next op. Iterative states count down and
  // write the result/flags in their final step, so an n-iteration op
  // raises out_valid n+1 cycles after its accept edge. Results and flags
  // only change when a new result is written, so they hold while the
  // consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_neg      <= 1'b0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_dirLeft  <= 1'b0;
      r_bigShift <= 1'b0;
`ifdef ALU_MUL_EN
      r_mcand    <= '0;
      r_mplier   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_state    <= w_nextState;
            r_work     <= a;
            r_cnt      <= w_amt;
            r_dirLeft  <= (op == OP_SHL);
            r_bigShift <= (b > WIDTH_W);
`ifdef ALU_MUL_EN
            r_mcand    <= a;
            r_mplier   <= b;
            if (op == OP_MUL) begin
              r_work <= '0;
              r_cnt  <= WIDTH_CNT;
            end
`endif
            if (w_nextState == ST_DONE) begin
              r_result <= w_res;
              r_zero   <= w_zero;
              r_carry  <= w_carry;
              r_neg    <= w_neg;
              r_ovf    <= w_ovf;
              r_err    <= w_err;
            end
          end else if ((r_state == ST_DONE) && out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_work <= w_shiftNext;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == 1) begin
            // Beyond WIDTH the shifted-out bit is defined as 0.
            r_state  <= ST_DONE;
            r_result <= w_shiftNext;
            r_zero   <= (w_shiftNext == '0);
            r_carry  <= w_shiftOut && !r_bigShift;
            r_neg    <= w_shiftNext[WIDTH-1];
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        ST_MUL: begin
          r_work   <= w_mulAcc;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == 1) begin
            r_state  <= ST_DONE;
            r_result <= w_mulAcc;
            r_zero   <= (w_mulAcc == '0);
            r_carry  <= 1'b0;
            r_neg    <= w_mulAcc[WIDTH-1];
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
//   Self-checking bench for alu_seq at WIDTH=16. Each op result, flag set and
//   accept-to-out_valid latency is compared with a behavioural model written
//   in plain integer arithmetic. Directed corner cases come first, then
//   reset-mid-shift, backpressure and a randomized run.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         negative;
  logic         overflow;
  logic         err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         n;
    logic         v;
    logic         e;
    int           lat;
  } expect_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .negative  (negative),
    .overflow  (overflow),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Behavioural reference: what each opcode should produce, computed with
  // integer arithmetic on the operand values.
  function automatic expect_t refModel(input logic [3:0] mop, input logic [W-1:0] ma,
                                       input logic [W-1:0] mb);
    expect_t      x;
    int unsigned  ua;
    int unsigned  ub;
    int           sa;
    int           sb;
    int           s;
    logic [W-1:0] d;
    ua = ma;
    ub = mb;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    x.res = '0;
    x.c   = 1'b0;
    x.v   = 1'b0;
    x.e   = 1'b0;
    x.lat = 1;
    case (mop)
      4'd0: begin
        x.res = W'(ua + ub);
        x.c   = (ua + ub) > 32'd65535;
        s     = sa + sb;
        x.v   = (s > 32767) || (s < -32768);
      end
      4'd1: begin
        x.res = W'(ua - ub);
        x.c   = ua < ub;
        s     = sa - sb;
        x.v   = (s > 32767) || (s < -32768);
      end
      4'd2: x.res = ~ma;
      4'd3: begin
        x.lat = 1 + ((ub > 16) ? 16 : int'(ub));
        if (ub == 0) x.res = ma;
        else if (ub <= 16) begin
          x.res = W'(ua << ub);
          x.c   = ma[16 - ub];
        end
      end
      4'd4: begin
        x.lat = 1 + ((ub > 16) ? 16 : int'(ub));
        if (ub == 0) x.res = ma;
        else if (ub <= 16) begin
          x.res = W'(ua >> ub);
          x.c   = ma[ub - 1];
        end
      end
      4'd5: x.res = ma & mb;
      4'd6: x.res = ma | mb;
      4'd7: begin
        x.res = (ua < ub) ? 16'd1 : 16'd0;
        x.c   = ua < ub;
        s     = sa - sb;
        x.v   = (s > 32767) || (s < -32768);
      end
`ifdef ALU_MUL_EN
      4'd8: begin
        x.res = W'(ua * ub);
        x.lat = W + 1;
      end
`endif
      default: x.e = 1'b1;
    endcase
    x.z = (x.res == '0);
    x.n = x.res[W-1];
    if (mop == 4'd7) begin
      d   = W'(ua - ub);
      x.z = (ua == ub);
      x.n = d[W-1];
    end
    return x;
  endfunction

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present an op at a falling edge, hold it through one rising edge, then
  // count cycles until out_valid (1 = visible right after the accept edge).
  task automatic applyStimulus(input logic [3:0] sop, input logic [W-1:0] sa,
                               input logic [W-1:0] sb, output int lat);
    int waitCnt;
    @(negedge clk);
    waitCnt = 0;
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    expectEq("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    op       = sop;
    a        = sa;
    b        = sb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic checkOutput(input logic [3:0] sop, input logic [W-1:0] sa,
                             input logic [W-1:0] sb, input int lat);
    expect_t x;
    x = refModel(sop, sa, sb);
    expectEq($sformatf("latency op%0d a=%0h b=%0h", sop, sa, sb), lat, x.lat);
    expectEq($sformatf("result op%0d a=%0h b=%0h", sop, sa, sb), {16'b0, result}, {16'b0, x.res});
    expectEq($sformatf("flags zcnve op%0d a=%0h b=%0h", sop, sa, sb),
             {27'b0, zero, carry, negative, overflow, err},
             {27'b0, x.z, x.c, x.n, x.v, x.e});
  endtask

  task automatic runOp(input logic [3:0] sop, input logic [W-1:0] sa, input logic [W-1:0] sb);
    int lat;
    applyStimulus(sop, sa, sb, lat);
    checkOutput(sop, sa, sb, lat);
  endtask

  initial begin
    logic [3:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           lat;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = '0;
    a         = '0;
    b         = '0;

    // Reset state: handshake outputs low while held, flags clear after.
    repeat (3) @(posedge clk);
    #1;
    expectEq("rst_in_ready", {31'b0, in_ready}, 32'd0);
    expectEq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expectEq("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    expectEq("post_rst_result", {16'b0, result}, 32'd0);
    expectEq("post_rst_flags", {27'b0, zero, carry, negative, overflow, err}, 32'd0);

    // Directed corner cases.
    runOp(4'd0, 16'hFFFF, 16'h0001);
    runOp(4'd0, 16'h7FFF, 16'h0001);
    runOp(4'd1, 16'd10, 16'd20);
    runOp(4'd7, 16'd1024, 16'd2048);
    runOp(4'd7, 16'd1024, 16'd512);
    runOp(4'd7, 16'd5, 16'd5);
    runOp(4'd3, 16'd1, 16'd3);
    runOp(4'd4, 16'd8, 16'd3);
    runOp(4'd4, 16'h8001, 16'd20);
    runOp(4'd3, 16'h8000, 16'd0);
    runOp(4'd3, 16'h8000, 16'd16);
    runOp(4'd4, 16'h0001, 16'd16);
    runOp(4'd2, 16'h00F0, 16'd0);
    runOp(4'd5, 16'h0F0F, 16'h00FF);
    runOp(4'd6, 16'h0F00, 16'h00F0);
    runOp(4'd8, 16'd300, 16'd7);
    runOp(4'd15, 16'h1234, 16'h5678);

    // Reset in the middle of a long shift: the shift is discarded.
    runOp(4'd0, 16'd3, 16'd4);
    @(negedge clk);
    op       = 4'd3;
    a        = 16'd1;
    b        = 16'd15;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    expectEq("midshift_rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    expectEq("midshift_rst_result", {16'b0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expectEq("midshift_post_in_ready", {31'b0, in_ready}, 32'd1);
    expectEq("midshift_post_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    expectEq("midshift_discarded", {31'b0, out_valid}, 32'd0);
    expectEq("midshift_result_held", {16'b0, result}, 32'd0);

    // Backpressure: result held while the consumer stalls, then a
    // back-to-back accept in the DONE state.
    out_ready = 1'b0;
    applyStimulus(4'd0, 16'd10, 16'd20, lat);
    checkOutput(4'd0, 16'd10, 16'd20, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expectEq("bp_out_valid", {31'b0, out_valid}, 32'd1);
      expectEq("bp_result", {16'b0, result}, 32'd30);
      expectEq("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    op        = 4'd5;
    a         = 16'd1;
    b         = 16'd1025;
    in_valid  = 1'b1;
    #1;
    expectEq("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expectEq("b2b_out_valid", {31'b0, out_valid}, 32'd1);
    expectEq("b2b_result", {16'b0, result}, 32'd1);
    @(posedge clk);
    #1;
    expectEq("b2b_released", {31'b0, out_valid}, 32'd0);

    // Randomized run: mostly legal ops, short-ish shift amounts.
    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 15));
      if (($urandom_range(0, 3) != 0) && (rop > 4'd8)) rop = 4'($urandom_range(0, 8));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if ((rop == 4'd3) || (rop == 4'd4)) rb = 16'($urandom_range(0, 20));
      runOp(rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
